// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - bundled handshake and data-RAM signals of the load/store unit
//
// Purpose: groups every non-clock port of lsu_mem.
// Signals:
//   up_valid/up_ready         instruction handshake from the EXU side
//   ctr_rd_en/ctr_wr_en       load / store decode
//   ctr_byt[2:0]              funct3 access size and signedness
//   exu_res                   effective byte address
//   gpr_rd_data               store data (rs2)
//   dn_valid/dn_ready         result handshake toward the LSU->WBU register
//   lsu_res/lsu_err           registered result and error flag
//   ram_req_valid/ready       data-RAM request handshake
//   ram_wr_en/addr            request type and word-aligned address
//   ram_wr_data/wr_mask       request write data and byte strobes
//   ram_rsp_valid/rd_data     response or write acknowledge, and read word
// Modports: slave = the load/store unit, master = its environment.
interface lsu_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  up_valid;
    logic                  up_ready;
    logic                  dn_valid;
    logic                  dn_ready;
    logic                  ctr_rd_en;
    logic                  ctr_wr_en;
    logic [2:0]            ctr_byt;
    logic [ADDR_WIDTH-1:0] exu_res;
    logic [31:0]           gpr_rd_data;
    logic                  ram_req_valid;
    logic                  ram_req_ready;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wr_data;
    logic [3:0]            ram_wr_mask;
    logic                  ram_rsp_valid;
    logic [31:0]           ram_rd_data;
    logic [31:0]           lsu_res;
    logic                  lsu_err;

    modport slave (
        input  up_valid, dn_ready, ctr_rd_en, ctr_wr_en, ctr_byt, exu_res, gpr_rd_data,
        input  ram_req_ready, ram_rsp_valid, ram_rd_data,
        output up_ready, dn_valid, lsu_res, lsu_err,
        output ram_req_valid, ram_wr_en, ram_addr, ram_wr_data, ram_wr_mask
    );

    modport master (
        output up_valid, dn_ready, ctr_rd_en, ctr_wr_en, ctr_byt, exu_res, gpr_rd_data,
        output ram_req_ready, ram_rsp_valid, ram_rd_data,
        input  up_ready, dn_valid, lsu_res, lsu_err,
        input  ram_req_valid, ram_wr_en, ram_addr, ram_wr_data, ram_wr_mask
    );
endinterface

// File: rtl/lsu_mem.sv
// rtl/lsu_mem.sv - load/store unit: one instruction per handshake, data-RAM request/response
//
// Purpose: accepts a decoded instruction, runs a data-RAM transaction for legal
// loads/stores, and returns an aligned, extended load result (or zero) with an
// error flag for misaligned/illegal accesses, which never reach the bus.
// Ports:
//   i_sys_clk    clock, rising edge
//   i_sys_rst_n  asynchronous active-low reset
//   bus          lsu_mem_if.slave (instruction, result and data-RAM signals)
module lsu_mem #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic     i_sys_clk,
    input  logic     i_sys_rst_n,
    lsu_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        illegal;
    logic [1:0]  in_lo;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        op_rd;
    logic [2:0]  op_byt;
    logic [1:0]  op_lo;
    logic [31:0] shifted;
    logic [31:0] ld_val;
    logic        load_res;
    logic [31:0] res_d;
    logic        err_d;

    assign bus.up_ready = (state == IDLE) && i_sys_rst_n;
    assign bus.dn_valid = (state == DONE);
    assign accept       = bus.up_valid && bus.up_ready;
    assign in_lo        = bus.exu_res[1:0];

    // Legality and store lane formatting, evaluated on the incoming instruction.
    always_comb begin
        illegal = bus.ctr_rd_en && bus.ctr_wr_en;
        st_data = bus.gpr_rd_data;
        st_mask = 4'b1111;
        case (bus.ctr_byt)
            3'b000, 3'b100: begin
                st_data = {4{bus.gpr_rd_data[7:0]}};
                st_mask = 4'b0001 << in_lo;
            end
            3'b001, 3'b101: begin
                illegal = illegal || in_lo[0];
                st_data = {2{bus.gpr_rd_data[15:0]}};
                st_mask = in_lo[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: illegal = illegal || (in_lo != 2'b00);
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (bus.ctr_wr_en && bus.ctr_byt[2]) begin
            illegal = 1'b1;
        end
    end

    // Load extraction from the latched offset and funct3.
    always_comb begin
        shifted = bus.ram_rd_data >> {op_lo, 3'b000};
        case (op_byt)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_val = {24'h000000, shifted[7:0]};
            3'b101:  ld_val = {16'h0000, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // load_res marks entry to DONE; res_d/err_d are what the result registers capture.
    always_comb begin
        next_state = state;
        load_res   = 1'b0;
        res_d      = 32'h0;
        err_d      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.ctr_rd_en && !bus.ctr_wr_en) begin
                        next_state = DONE;
                        load_res   = 1'b1;
                    end else if (illegal) begin
                        next_state = DONE;
                        load_res   = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.ram_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.ram_rsp_valid) begin
                    next_state = DONE;
                    load_res   = 1'b1;
                    res_d      = op_rd ? ld_val : 32'h0;
                end
            end
            DONE: begin
                if (bus.dn_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus fields are captured at acceptance so they stay frozen through REQ.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            op_rd             <= 1'b0;
            op_byt            <= 3'b000;
            op_lo             <= 2'b00;
            bus.ram_req_valid <= 1'b0;
            bus.ram_wr_en     <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_wr_data   <= 32'h0;
            bus.ram_wr_mask   <= 4'b0000;
            bus.lsu_res       <= 32'h0;
            bus.lsu_err       <= 1'b0;
        end else begin
            bus.ram_req_valid <= (next_state == REQ);
            if (accept) begin
                op_rd           <= bus.ctr_rd_en;
                op_byt          <= bus.ctr_byt;
                op_lo           <= in_lo;
                bus.ram_wr_en   <= bus.ctr_wr_en;
                bus.ram_addr    <= {bus.exu_res[ADDR_WIDTH-1:2], 2'b00};
                bus.ram_wr_data <= st_data;
                bus.ram_wr_mask <= bus.ctr_wr_en ? st_mask : 4'b0000;
            end
            if (load_res) begin
                bus.lsu_res <= res_d;
                bus.lsu_err <= err_d;
            end
        end
    end
endmodule
